// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the ROM address and fills the IF/ID register.
// Optional misaligned-redirect trap enabled with `define FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_target_i,
   input  logic [DATA_WIDTH-1:0] instr_i,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  if_id_valid_o,
   output logic [DATA_WIDTH-1:0] if_id_instr_o,
   output logic [DATA_WIDTH-1:0] if_id_pc_o,
   output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
   output logic [31:0]           instr_count_o,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic                  misaligned_o,
`endif
   output logic [1:0]            state_o
);

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      RUN     = 2'd1,
      STALLED = 2'd2,
      TRAP    = 2'd3
   } state_t;

   localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(4);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MK = ~DATA_WIDTH'(3);

   state_t                  state_p0;
   logic [DATA_WIDTH-1:0]   pc_p0;
   logic [DATA_WIDTH-1:0]   pc_plus4;
   logic [DATA_WIDTH-1:0]   redirect_pc;

   assign pc_plus4    = pc_p0 + PC_STEP;
   assign redirect_pc = redirect_target_i & ALIGN_MK;
   assign pc_o        = pc_p0;
   assign state_o     = state_p0;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic misaligned_tgt;
   assign misaligned_tgt = |redirect_target_i[1:0];
`endif

   // Stage p0: PC register and IF/ID capture; a bubble keeps the old pc fields
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_p0            <= RESET_PC;
         state_p0         <= BOOT;
         if_id_valid_o    <= 1'b0;
         if_id_instr_o    <= NOP_INSTR;
         if_id_pc_o       <= '0;
         if_id_pc_plus4_o <= '0;
         instr_count_o    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misaligned_o     <= 1'b0;
`endif
      end else begin
         case (state_p0)
            BOOT: begin
               if_id_valid_o <= 1'b0;
               if_id_instr_o <= NOP_INSTR;
               state_p0      <= RUN;
            end
            RUN, STALLED: begin
               if (redirect_i) begin
                  if_id_valid_o <= 1'b0;
                  if_id_instr_o <= NOP_INSTR;
`ifdef FETCH_MISALIGN_TRAP_EN
                  if (misaligned_tgt) begin
                     misaligned_o <= 1'b1;
                     state_p0     <= TRAP;
                  end else begin
                     pc_p0    <= redirect_pc;
                     state_p0 <= RUN;
                  end
`else
                  pc_p0    <= redirect_pc;
                  state_p0 <= RUN;
`endif
               end else if (stall_i) begin
                  state_p0 <= STALLED;
                  if (flush_i) begin
                     if_id_valid_o <= 1'b0;
                     if_id_instr_o <= NOP_INSTR;
                  end
               end else begin
                  state_p0 <= RUN;
                  pc_p0    <= pc_plus4;
                  if (flush_i) begin
                     if_id_valid_o <= 1'b0;
                     if_id_instr_o <= NOP_INSTR;
                  end else begin
                     if_id_valid_o    <= 1'b1;
                     if_id_instr_o    <= instr_i;
                     if_id_pc_o       <= pc_p0;
                     if_id_pc_plus4_o <= pc_plus4;
                     instr_count_o    <= instr_count_o + 32'd1;
                  end
               end
            end
            TRAP: begin
               if_id_valid_o <= 1'b0;
               if_id_instr_o <= NOP_INSTR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural reference pushes expected outputs per cycle.
// Covers both builds via FETCH_MISALIGN_TRAP_EN.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst, stall_i, flush_i, redirect_i;
   logic [31:0] redirect_target_i, instr_i;
   logic [31:0] pc_o, if_id_instr_o, if_id_pc_o, if_id_pc_plus4_o, instr_count_o;
   logic        if_id_valid_o;
   logic [1:0]  state_o;
   logic        mis_w;

   fetch_stage dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .redirect_i(redirect_i), .redirect_target_i(redirect_target_i),
      .instr_i(instr_i), .pc_o(pc_o), .if_id_valid_o(if_id_valid_o),
      .if_id_instr_o(if_id_instr_o), .if_id_pc_o(if_id_pc_o),
      .if_id_pc_plus4_o(if_id_pc_plus4_o), .instr_count_o(instr_count_o),
`ifdef FETCH_MISALIGN_TRAP_EN
      .misaligned_o(mis_w),
`endif
      .state_o(state_o)
   );
`ifndef FETCH_MISALIGN_TRAP_EN
   assign mis_w = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction
   assign instr_i = rom(pc_o);

   typedef struct packed {
      logic [1:0]  st;
      logic        mis;
      logic        v;
      logic [31:0] ins, pc, ifpc, ifpc4, cnt;
   } snap_t;

   snap_t obs, exp_s;
   assign obs = {state_o, mis_w, if_id_valid_o, if_id_instr_o, pc_o,
                 if_id_pc_o, if_id_pc_plus4_o, instr_count_o};

   snap_t sb[$];
   int n_run = 0, n_fail = 0;

   logic [1:0]  m_st;
   logic        m_mis, m_v;
   logic [31:0] m_ins, m_pc, m_ifpc, m_ifpc4, m_cnt;

   task automatic cycle(input logic s, input logic f, input logic r,
                        input logic [31:0] t, input logic rs);
      rst = rs; stall_i = s; flush_i = f; redirect_i = r; redirect_target_i = t;
      if (rs) begin
         m_st = 2'd0; m_mis = 1'b0; m_v = 1'b0; m_ins = 32'h13;
         m_pc = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_cnt = 32'h0;
      end else if (m_st == 2'd0) begin
         m_v = 1'b0; m_ins = 32'h13; m_st = 2'd1;
      end else if (m_st == 2'd3) begin
         m_v = 1'b0; m_ins = 32'h13;
      end else if (r) begin
         m_v = 1'b0; m_ins = 32'h13;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (t[1:0] != 2'b00) begin m_mis = 1'b1; m_st = 2'd3; end
         else begin m_pc = t; m_st = 2'd1; end
`else
         m_pc = {t[31:2], 2'b00}; m_st = 2'd1;
`endif
      end else if (s) begin
         m_st = 2'd2;
         if (f) begin m_v = 1'b0; m_ins = 32'h13; end
      end else begin
         m_st = 2'd1;
         if (f) begin m_v = 1'b0; m_ins = 32'h13; end
         else begin
            m_v = 1'b1; m_ins = rom(m_pc); m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
         end
         m_pc = m_pc + 32'd4;
      end
      sb.push_back({m_st, m_mis, m_v, m_ins, m_pc, m_ifpc, m_ifpc4, m_cnt});
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b1, 1'b1, 32'h40, 1'b1);
         exp_s = sb.pop_front(); n_run++;
         if (obs !== exp_s) begin n_fail++; $display("FAIL reset: got %h want %h", obs, exp_s); end
      end
      n_run++;
      if (state_o !== 2'd0 || if_id_instr_o !== 32'h13 || if_id_valid_o !== 1'b0 || pc_o !== 32'h0) begin
         n_fail++; $display("FAIL reset_vals: got st=%0d ins=%h v=%b pc=%h want 0/00000013/0/0",
                            state_o, if_id_instr_o, if_id_valid_o, pc_o);
      end
   endtask

   task automatic test_run();
      // BOOT ignores stall/flush/redirect
      cycle(1'b1, 1'b1, 1'b1, 32'h80, 1'b0);
      exp_s = sb.pop_front(); n_run++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL boot: got %h want %h", obs, exp_s); end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         exp_s = sb.pop_front(); n_run++;
         if (obs !== exp_s) begin n_fail++; $display("FAIL run%0d: got %h want %h", i, obs, exp_s); end
      end
      n_run++;
      if (pc_o !== 32'h8 || instr_count_o !== 32'd2 || if_id_pc_plus4_o !== 32'h8) begin
         n_fail++; $display("FAIL run_end: got pc=%h cnt=%0d pc4=%h want 8/2/8", pc_o, instr_count_o, if_id_pc_plus4_o);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
         exp_s = sb.pop_front(); n_run++;
         if (obs !== exp_s) begin n_fail++; $display("FAIL stall%0d: got %h want %h", i, obs, exp_s); end
      end
      n_run++;
      if (state_o !== 2'd2 || pc_o !== 32'h8) begin
         n_fail++; $display("FAIL stall_state: got st=%0d pc=%h want 2/8", state_o, pc_o);
      end
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      exp_s = sb.pop_front(); n_run++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL stall_rel: got %h want %h", obs, exp_s); end
      n_run++;
      if (state_o !== 2'd1 || if_id_pc_o !== 32'h8 || instr_count_o !== 32'd3) begin
         n_fail++; $display("FAIL stall_exit: got st=%0d ifpc=%h cnt=%0d want 1/8/3", state_o, if_id_pc_o, instr_count_o);
      end
   endtask

   task automatic test_redirect();
      cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
      exp_s = sb.pop_front(); n_run++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL redir: got %h want %h", obs, exp_s); end
      n_run++;
      if (pc_o !== 32'h40 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13 || instr_count_o !== 32'd3) begin
         n_fail++; $display("FAIL redir_vals: got pc=%h v=%b ins=%h cnt=%0d want 40/0/00000013/3",
                            pc_o, if_id_valid_o, if_id_instr_o, instr_count_o);
      end
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      exp_s = sb.pop_front(); n_run++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL redir_next: got %h want %h", obs, exp_s); end
      n_run++;
      if (if_id_instr_o !== rom(32'h40) || if_id_pc_o !== 32'h40) begin
         n_fail++; $display("FAIL redir_cap: got ins=%h pc=%h want %h/40", if_id_instr_o, if_id_pc_o, rom(32'h40));
      end
   endtask

   task automatic test_flush();
      // redirect to 0x10, stall+flush, normal, flush alone, normal
      logic [3:0] tab_s [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       tab_f [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic       tab_r [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         cycle(tab_s[i][0], tab_f[i], tab_r[i], 32'h10, 1'b0);
         exp_s = sb.pop_front(); n_run++;
         if (obs !== exp_s) begin n_fail++; $display("FAIL flush%0d: got %h want %h", i, obs, exp_s); end
         if (i == 1) begin
            n_run++;
            if (pc_o !== 32'h10 || if_id_valid_o !== 1'b0) begin
               n_fail++; $display("FAIL flush_stall: got pc=%h v=%b want 10/0", pc_o, if_id_valid_o);
            end
         end
      end
   endtask

   task automatic test_wrap();
      cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      exp_s = sb.pop_front(); n_run++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL wrap_redir: got %h want %h", obs, exp_s); end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         exp_s = sb.pop_front(); n_run++;
         if (obs !== exp_s) begin n_fail++; $display("FAIL wrap%0d: got %h want %h", i, obs, exp_s); end
         if (i == 0) begin
            n_run++;
            if (pc_o !== 32'h0 || if_id_pc_plus4_o !== 32'h0 || if_id_pc_o !== 32'hFFFF_FFFC) begin
               n_fail++; $display("FAIL wrap_pc: got pc=%h pc4=%h ifpc=%h want 0/0/fffffffc",
                                  pc_o, if_id_pc_plus4_o, if_id_pc_o);
            end
         end
      end
      cycle(1'b0, 1'b0, 1'b1, 32'h80, 1'b1);
      exp_s = sb.pop_front(); n_run++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL midrst: got %h want %h", obs, exp_s); end
      n_run++;
      if (instr_count_o !== 32'd0 || pc_o !== 32'h0 || state_o !== 2'd0 || if_id_pc_o !== 32'h0) begin
         n_fail++; $display("FAIL midrst_vals: got cnt=%0d pc=%h st=%0d ifpc=%h want 0", instr_count_o, pc_o, state_o, if_id_pc_o);
      end
   endtask

   task automatic test_misalign();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 32'h42, 1'b0);
      for (int i = 0; i < 3; i++) begin
         exp_s = sb.pop_front();
         if (i == 2) begin
            n_run++;
            if (obs !== exp_s) begin n_fail++; $display("FAIL mis_redir: got %h want %h", obs, exp_s); end
         end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      n_run++;
      if (mis_w !== 1'b1 || state_o !== 2'd3 || pc_o !== 32'h4) begin
         n_fail++; $display("FAIL trap: got mis=%b st=%0d pc=%h want 1/3/4", mis_w, state_o, pc_o);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 32'h100, 1'b0);
         exp_s = sb.pop_front(); n_run++;
         if (obs !== exp_s) begin n_fail++; $display("FAIL trap_hold%0d: got %h want %h", i, obs, exp_s); end
      end
`else
      n_run++;
      if (pc_o !== 32'h40 || state_o !== 2'd1) begin
         n_fail++; $display("FAIL align: got pc=%h st=%0d want 40/1", pc_o, state_o);
      end
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      exp_s = sb.pop_front(); n_run++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL align_next: got %h want %h", obs, exp_s); end
`endif
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      exp_s = sb.pop_front(); n_run++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL mis_rst: got %h want %h", obs, exp_s); end
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_target_i = '0;
      @(posedge clk); #1;
      test_reset();
      test_run();
      test_stall();
      test_redirect();
      test_flush();
      test_wrap();
      test_misalign();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
